// File: rtl/multicycle_pipe_if.sv
// Producer-side handshake and last-stage output bundle for multicycle_pipe.
interface multicycle_pipe_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_strobe;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, out_strobe
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, out_strobe
  );
endinterface

// File: rtl/multicycle_pipe.sv
// Single-clock decode pipeline: a programmable divider produces a stage
// enable, a valid/ready hold register feeds STAGES enable-gated transform
// stages. Logic between stages is a multicycle path of div_ratio cycles.
module multicycle_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int DIV_W  = 4
) (
  input  logic             fast_clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             mode,
  output logic             en_pulse,
  multicycle_pipe_if.slave bus
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q;
  logic [DIV_W-1:0] r_eff;
  logic             mode_q;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [WIDTH-1:0] st_q [STAGES];
  logic [WIDTH-1:0] st_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES:0]  v_src;
  logic             strobe_q, strobe_d;
  logic             accept;

  // Decode transform: mode 1 gates even bits and forces odd bits with x[1].
  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x,
                                             input logic m);
    logic [WIDTH-1:0] y;
    y = x;
    if (m) begin
      y[0] = x[1] & x[0];
      y[1] = x[1];
      for (int unsigned i = 2; i < WIDTH; i++) begin
        y[i] = (i % 2 == 0) ? (x[i] & x[1]) : (x[i] | x[1]);
      end
    end
    return y;
  endfunction

  // Wrap on >= so a counter already past a smaller ratio still wraps.
  assign r_eff    = (ratio_q == '0) ? DIV_W'(1) : ratio_q;
  assign en_pulse = (cnt_q >= r_eff - DIV_W'(1));
  assign accept   = bus.in_valid && !hold_full_q;

  // Valid chain: index 0 is the hold register, index k+1 is stage k.
  assign v_src = {v_q, hold_full_q};

  assign bus.in_ready   = !hold_full_q;
  assign bus.out_data   = st_q[STAGES-1];
  assign bus.out_valid  = v_src[STAGES];
  assign bus.out_strobe = strobe_q;

  // Next-state for divider, hold register and stage chain.
  always_comb begin
    cnt_d       = en_pulse ? '0 : cnt_q + DIV_W'(1);
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    st_d        = st_q;
    v_d         = v_q;
    strobe_d    = 1'b0;
    if (en_pulse) begin
      st_d[0] = xform(hold_data_q, mode_q);
      for (int unsigned k = 1; k < STAGES; k++) begin
        st_d[k] = xform(st_q[k-1], mode_q);
      end
      v_d         = v_src[STAGES-1:0];
      strobe_d    = v_src[STAGES-1];
      hold_full_d = 1'b0;
    end
    // Accept only possible while empty, so it never collides with a move.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.in_data;
    end
  end

  // State registers; ratio and mode are sampled only at period boundaries.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ratio_q     <= '0;
      mode_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      st_q        <= '{default: '0};
      v_q         <= '0;
      strobe_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      st_q        <= st_d;
      v_q         <= v_d;
      strobe_q    <= strobe_d;
      if (en_pulse) begin
        ratio_q <= div_ratio;
        mode_q  <= mode;
      end
    end
  end

endmodule
